// File: rtl/avalon_multi_timer.sv
// Multi-channel Avalon-MM down-counting timer with per-channel prescaler,
// one-shot/continuous modes, counter snapshot and level interrupts.
module avalon_multi_timer #(
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 32,
  parameter int DEFAULT_PERIOD = 11999,
  localparam int ADDR_W = ($clog2(CHANNELS) + 2 < 3) ? 3 : $clog2(CHANNELS) + 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [CHANNELS-1:0] irq,
  output logic                irq_any
);

  localparam int CH_W = ADDR_W - 2;

  logic [CH_W-1:0] w_chan;
  logic [1:0]      w_reg;
  logic            w_wr;
  logic            w_unused;

  assign w_chan   = address[ADDR_W-1:2];
  assign w_reg    = address[1:0];
  assign w_wr     = chipselect & ~write_n;
  assign w_unused = ^writedata;

  logic             r_to       [CHANNELS];
  logic             r_run      [CHANNELS];
  logic             r_ito      [CHANNELS];
  logic             r_cont     [CHANNELS];
  logic [7:0]       r_presc    [CHANNELS];
  logic [7:0]       r_prescCnt [CHANNELS];
  logic [WIDTH-1:0] r_period   [CHANNELS];
  logic [WIDTH-1:0] r_count    [CHANNELS];
  logic [WIDTH-1:0] r_snap     [CHANNELS];
  logic [31:0]      r_readdata;

  logic [CHANNELS-1:0] w_wrStatus;
  logic [CHANNELS-1:0] w_wrCtrl;
  logic [CHANNELS-1:0] w_wrPeriod;
  logic [CHANNELS-1:0] w_wrSnap;
  logic [CHANNELS-1:0] w_start;
  logic [CHANNELS-1:0] w_stop;
  logic [CHANNELS-1:0] w_tick;
  logic [CHANNELS-1:0] w_timeout;
  logic [31:0]         w_rdata;

  // A PERIOD write, START or STOP on a channel takes over that cycle, so no tick fires then.
  always_comb begin
    w_wrStatus = '0;
    w_wrCtrl   = '0;
    w_wrPeriod = '0;
    w_wrSnap   = '0;
    w_start    = '0;
    w_stop     = '0;
    w_tick     = '0;
    w_timeout  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_wrStatus[i] = w_wr && (w_chan == CH_W'(i)) && (w_reg == 2'd0);
      w_wrCtrl[i]   = w_wr && (w_chan == CH_W'(i)) && (w_reg == 2'd1);
      w_wrPeriod[i] = w_wr && (w_chan == CH_W'(i)) && (w_reg == 2'd2);
      w_wrSnap[i]   = w_wr && (w_chan == CH_W'(i)) && (w_reg == 2'd3);
      w_start[i]    = w_wrCtrl[i] && writedata[2];
      w_stop[i]     = w_wrCtrl[i] && writedata[3];
      w_tick[i]     = r_run[i] && (r_prescCnt[i] == r_presc[i]) &&
                      !w_wrPeriod[i] && !w_start[i] && !w_stop[i];
      w_timeout[i]  = w_tick[i] && (r_count[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!reset_n) begin
        r_to[i]       <= 1'b0;
        r_run[i]      <= 1'b0;
        r_ito[i]      <= 1'b0;
        r_cont[i]     <= 1'b0;
        r_presc[i]    <= 8'd0;
        r_prescCnt[i] <= 8'd0;
        r_period[i]   <= WIDTH'(DEFAULT_PERIOD);
        r_count[i]    <= WIDTH'(DEFAULT_PERIOD);
        r_snap[i]     <= '0;
      end else begin
        if (w_wrCtrl[i]) begin
          r_ito[i]   <= writedata[0];
          r_cont[i]  <= writedata[1];
          r_presc[i] <= writedata[15:8];
        end

        if (w_wrPeriod[i]) begin
          r_period[i]   <= writedata[WIDTH-1:0];
          r_count[i]    <= writedata[WIDTH-1:0];
          r_run[i]      <= 1'b0;
          r_prescCnt[i] <= 8'd0;
        end else if (w_start[i]) begin
          r_count[i]    <= r_period[i];
          r_run[i]      <= 1'b1;
          r_prescCnt[i] <= 8'd0;
        end else if (w_stop[i]) begin
          r_run[i]      <= 1'b0;
          r_prescCnt[i] <= 8'd0;
        end else if (!r_run[i]) begin
          r_prescCnt[i] <= 8'd0;
        end else if (w_tick[i]) begin
          r_prescCnt[i] <= 8'd0;
          if (r_count[i] != '0) begin
            r_count[i] <= r_count[i] - WIDTH'(1);
          end else begin
            r_count[i] <= r_period[i];
            if (!r_cont[i]) begin
              r_run[i] <= 1'b0;
            end
          end
        end else begin
          r_prescCnt[i] <= r_prescCnt[i] + 8'd1;
        end

        // A timeout in the same cycle as a STATUS write keeps TO set.
        if (w_timeout[i]) begin
          r_to[i] <= 1'b1;
        end else if (w_wrStatus[i]) begin
          r_to[i] <= 1'b0;
        end

        if (w_wrSnap[i]) begin
          r_snap[i] <= r_count[i];
        end
      end
    end
  end

  // Channel indices beyond CHANNELS match no loop entry and read as zero.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_chan == CH_W'(i)) begin
        case (w_reg)
          2'd0: w_rdata = {30'd0, r_run[i], r_to[i]};
          2'd1: w_rdata = {16'd0, r_presc[i], 6'd0, r_cont[i], r_ito[i]};
          2'd2: w_rdata = 32'(r_period[i]);
          2'd3: w_rdata = 32'(r_snap[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  always_comb begin
    irq = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      irq[i] = r_to[i] & r_ito[i];
    end
  end

  assign irq_any  = |irq;
  assign readdata = r_readdata;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed bench for avalon_multi_timer: three channels of 16 bits so that
// truncation, zero-extension and an unmapped channel index are all reachable.
module tb_avalon_multi_timer;

  localparam int CHANNELS = 3;
  localparam int WIDTH    = 16;
  localparam int ADDR_W   = 4;

  logic                clk;
  logic                reset_n;
  logic                chipselect;
  logic                write_n;
  logic [ADDR_W-1:0]   address;
  logic [31:0]         writedata;
  logic [31:0]         readdata;
  logic [CHANNELS-1:0] irq;
  logic                irq_any;

  int checks;
  int failures;
  logic [31:0] rdVal;

  avalon_multi_timer #(
    .CHANNELS(CHANNELS),
    .WIDTH(WIDTH),
    .DEFAULT_PERIOD(11999)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .chipselect(chipselect),
    .write_n(write_n),
    .address(address),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .irq_any(irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One bus write; returns #1 after the edge that commits it.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [ADDR_W-1:0] addr, output logic [31:0] data);
    address = addr;
    @(posedge clk);
    #1;
    data = readdata;
  endtask

  task automatic readCheck(input logic [ADDR_W-1:0] addr, input logic [31:0] expected,
                           input string tag);
    logic [31:0] value;
    readReg(addr, value);
    checkOutput(tag, value, expected);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetReaddata", readdata, 32'd0);
    checkOutput("resetIrq", {29'd0, irq}, 32'd0);
    checkOutput("resetIrqAny", {31'd0, irq_any}, 32'd0);
    reset_n = 1'b1;
    readCheck(4'd2, 32'd11999, "initPeriod0");
    readCheck(4'd1, 32'd0, "initControl0");
    readCheck(4'd7, 32'd0, "initSnap1");

    // Continuous mode, PERIOD=3: counter runs 3,2,1,0,3,2,1...
    applyStimulus(4'd2, 32'd3);
    applyStimulus(4'd1, 32'h6);
    applyStimulus(4'd3, 32'd0);
    readCheck(4'd3, 32'd3, "contSnapStart");
    readCheck(4'd0, 32'd2, "contStatusRunNoTo");
    applyStimulus(4'd3, 32'd0);
    readCheck(4'd3, 32'd0, "contSnapZero");
    readCheck(4'd0, 32'd3, "contStatusTimeout");
    applyStimulus(4'd3, 32'd0);
    readCheck(4'd3, 32'd1, "contSnapAfterReload");
    checkOutput("contIrqMasked", {29'd0, irq}, 32'd0);
    applyStimulus(4'd1, 32'h8);
    applyStimulus(4'd0, 32'd0);

    // One-shot with interrupt on channel 1, PERIOD=2: timeout on the third tick.
    applyStimulus(4'd6, 32'd2);
    applyStimulus(4'd5, 32'h5);
    idle(2);
    checkOutput("oneShotIrqEarly", {29'd0, irq}, 32'd0);
    idle(1);
    checkOutput("oneShotIrq", {29'd0, irq}, 32'b010);
    checkOutput("oneShotIrqAny", {31'd0, irq_any}, 32'd1);
    readCheck(4'd4, 32'd1, "oneShotStatus");
    applyStimulus(4'd4, 32'd0);
    checkOutput("irqClearedByStatus", {29'd0, irq}, 32'd0);
    checkOutput("irqAnyCleared", {31'd0, irq_any}, 32'd0);
    readCheck(4'd0, 32'd0, "ch0Isolated");

    // Prescale 3 (4 clocks per tick), PERIOD=1: timeout 8 clocks after START.
    applyStimulus(4'd2, 32'd1);
    applyStimulus(4'd1, 32'h0305);
    idle(7);
    checkOutput("prescNoTimeoutYet", {29'd0, irq}, 32'd0);
    idle(1);
    checkOutput("prescTimeoutIrq", {29'd0, irq}, 32'b001);
    checkOutput("prescTimeoutIrqAny", {31'd0, irq_any}, 32'd1);
    readCheck(4'd4, 32'd0, "ch1Unaffected");
    readCheck(4'd0, 32'd1, "prescStatusOneShot");
    readCheck(4'd1, 32'h0301, "controlReadback");

    // STATUS write landing on the timeout cycle leaves TO set.
    applyStimulus(4'd0, 32'd0);
    applyStimulus(4'd2, 32'd1);
    applyStimulus(4'd1, 32'h6);
    idle(1);
    applyStimulus(4'd0, 32'd0);
    readCheck(4'd0, 32'd3, "toSetWinsOverClear");
    applyStimulus(4'd1, 32'h8);
    readReg(4'd0, rdVal);
    checkOutput("stopClearsRun", {31'd0, rdVal[1]}, 32'd0);
    applyStimulus(4'd1, 32'hC);
    readReg(4'd0, rdVal);
    checkOutput("startWinsOverStop", {31'd0, rdVal[1]}, 32'd1);
    readCheck(4'd1, 32'd0, "strobesReadZero");

    // Snapshot at 0x1234, then PERIOD write while running.
    applyStimulus(4'd2, 32'h1240);
    applyStimulus(4'd1, 32'h6);
    idle(12);
    applyStimulus(4'd3, 32'hFFFF_FFFF);
    checkOutput("snapReadLatency", readdata, 32'd1);
    readCheck(4'd3, 32'h0000_1234, "snapCaptured");
    applyStimulus(4'd2, 32'h50);
    readCheck(4'd0, 32'd1, "periodWriteStopsRun");
    applyStimulus(4'd3, 32'd0);
    readCheck(4'd3, 32'h50, "periodWriteLoadsCount");
    applyStimulus(4'd6, 32'hABCD_0077);
    readCheck(4'd6, 32'h77, "periodTruncZeroExt");
    readCheck(4'd14, 32'd0, "unmappedChannel");

    // One-cycle reset mid-count, overriding a simultaneous START on channel 1.
    applyStimulus(4'd1, 32'h6);
    idle(3);
    reset_n    = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 4'd5;
    writedata  = 32'h5;
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    checkOutput("midResetReaddata", readdata, 32'd0);
    checkOutput("midResetIrqAny", {31'd0, irq_any}, 32'd0);
    readCheck(4'd2, 32'd11999, "midResetPeriod0");
    readCheck(4'd0, 32'd0, "midResetStatus0");
    readCheck(4'd4, 32'd0, "midResetStatus1");
    readCheck(4'd1, 32'd0, "midResetControl0");
    readCheck(4'd3, 32'd0, "midResetSnap0");
    applyStimulus(4'd3, 32'd0);
    readCheck(4'd3, 32'd11999, "midResetCounter0");
    readCheck(4'd6, 32'd11999, "midResetPeriod1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
